dmux16_stream: RTL and testbench



---
 rtl/dmux16_stream.sv | 115 +++++++++++
 tb/tb_dmux16_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmux16_stream.sv
// dmux16_stream: routes a 16-bit word stream to one of two ports, each port
// buffered by its own DEPTH-entry FIFO so a stalled sink never blocks the other.

// Per-port circular FIFO; head entry is driven straight from storage.
module dmux16_fifo #(
   parameter int DEPTH = 2,
   parameter int LW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [15:0]   data_i,
   input  logic          pop_req_i,
   output logic          full_o,
   output logic          valid_o,
   output logic [15:0]   data_o,
   output logic [LW-1:0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][15:0] mem_q;
   logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]          lvl_q, lvl_d;
   logic                   pop;

   assign valid_o = (lvl_q != '0);
   assign full_o  = (lvl_q == LW'(DEPTH));
   // Ready on an empty port is ignored so pointers and level never underflow.
   assign pop     = pop_req_i & valid_o;
   assign data_o  = mem_q[rd_q];
   assign level_o = lvl_q;

   // Next-state pointers and occupancy; DEPTH is a power of two so the
   // pointers wrap naturally.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop)    rd_d = rd_q + AW'(1);
      case ({push_i, pop})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   // State and storage; storage is cleared so the data outputs read 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
         if (push_i) mem_q[wr_q] <= data_i;
      end
   end
endmodule

module dmux16_stream #(
   parameter int DEPTH = 2,
   parameter int LW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_data,
   input  logic          in_sel,
   output logic          a_valid,
   input  logic          a_ready,
   output logic [15:0]   a_data,
   output logic [LW-1:0] a_level,
   output logic          b_valid,
   input  logic          b_ready,
   output logic [15:0]   b_data,
   output logic [LW-1:0] b_level
);
   localparam int NPORT = 2;

   logic [NPORT-1:0]          full_w, valid_w, push_w, pop_req_w;
   logic [NPORT-1:0][15:0]    data_w;
   logic [NPORT-1:0][LW-1:0]  lvl_w;

   // Acceptance looks only at the selected port's full flag, so there is no
   // path from either consumer ready to in_ready (no pass-through on full).
   assign in_ready  = ~full_w[in_sel];
   assign push_w    = {in_sel, ~in_sel} & {NPORT{in_valid & in_ready}};
   assign pop_req_w = {b_ready, a_ready};

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      dmux16_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push_i    (push_w[p]),
         .data_i    (in_data),
         .pop_req_i (pop_req_w[p]),
         .full_o    (full_w[p]),
         .valid_o   (valid_w[p]),
         .data_o    (data_w[p]),
         .level_o   (lvl_w[p])
      );
   end

   assign a_valid = valid_w[0];
   assign a_data  = data_w[0];
   assign a_level = lvl_w[0];
   assign b_valid = valid_w[1];
   assign b_data  = data_w[1];
   assign b_level = lvl_w[1];
endmodule

// File: tb/tb_dmux16_stream.sv
// Bench for dmux16_stream: directed pushes feed per-port expectation queues,
// a negedge monitor checks every word the DUT hands to a consumer.
module tb_dmux16_stream;
   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_sel;
   logic [15:0]   in_data;
   logic          a_valid, a_ready, b_valid, b_ready;
   logic [15:0]   a_data, b_data;
   logic [LW-1:0] a_level, b_level;

   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   int n_checks = 0;
   int n_fail   = 0;

   dmux16_stream #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_level(a_level),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_level(b_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Offer one word, wait (bounded) for acceptance, record the expectation.
   // Called and returns 1 time unit after a rising edge.
   task automatic send(input logic [15:0] d, input logic s);
      int waitc = 0;
      in_valid = 1'b1; in_data = d; in_sel = s;
      @(negedge clk);
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: word 0x%0h never accepted", d);
      end else if (s) exp_b.push_back(d);
      else            exp_a.push_back(d);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake a consumer will complete at the next edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            if (exp_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_unexpected: got 0x%0h expected no word", a_data);
            end else check("a_data", {16'h0, a_data}, {16'h0, exp_a.pop_front()});
         end
         if (b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b_unexpected: got 0x%0h expected no word", b_data);
            end else check("b_data", {16'h0, b_data}, {16'h0, exp_b.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      a_ready = 1'b0; b_ready = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // Reset / idle state
      @(negedge clk);
      check("rst_in_ready", {31'h0, in_ready}, 1);
      check("rst_a_valid",  {31'h0, a_valid}, 0);
      check("rst_b_valid",  {31'h0, b_valid}, 0);
      check("rst_a_level",  {30'h0, a_level}, 0);
      check("rst_b_level",  {30'h0, b_level}, 0);
      check("rst_a_data",   {16'h0, a_data}, 0);
      check("rst_b_data",   {16'h0, b_data}, 0);
      @(posedge clk); #1;

      // Alternate routing with both consumers ready
      a_ready = 1'b1; b_ready = 1'b1;
      send(16'h1111, 1'b0);
      check("lat_a_valid", {31'h0, a_valid}, 1);
      check("lat_a_data",  {16'h0, a_data}, 32'h1111);
      check("lat_a_level", {30'h0, a_level}, 1);
      send(16'h2222, 1'b1);
      check("lat_b_valid", {31'h0, b_valid}, 1);
      check("lat_b_data",  {16'h0, b_data}, 32'h2222);
      send(16'h3333, 1'b0);
      idle(3);
      check("alt_a_level", {30'h0, a_level}, 0);
      check("alt_b_level", {30'h0, b_level}, 0);

      // Full and blocking
      a_ready = 1'b0; b_ready = 1'b0;
      send(16'hAAA1, 1'b0);
      send(16'hAAA2, 1'b0);
      check("full_a_level", {30'h0, a_level}, 2);
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hDEAD;
      #1 check("full_in_ready_sel0", {31'h0, in_ready}, 0);
      in_sel = 1'b1;
      #1 check("full_in_ready_sel1", {31'h0, in_ready}, 1);
      send(16'hBBB1, 1'b1);
      check("blk_b_level", {30'h0, b_level}, 1);
      check("blk_b_data",  {16'h0, b_data}, 32'hBBB1);
      check("blk_a_level", {30'h0, a_level}, 2);

      // Full with simultaneous pop: no pass-through
      a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hAAA3;
      @(negedge clk);
      check("fpop_in_ready", {31'h0, in_ready}, 0);
      @(posedge clk); #1;
      a_ready = 1'b0;
      check("fpop_a_level1", {30'h0, a_level}, 1);
      check("fpop_in_ready_next", {31'h0, in_ready}, 1);
      @(negedge clk);
      exp_a.push_back(16'hAAA3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("fpop_a_level2", {30'h0, a_level}, 2);
      a_ready = 1'b1; b_ready = 1'b1;
      idle(5);
      check("drain_a_level", {30'h0, a_level}, 0);
      check("drain_b_level", {30'h0, b_level}, 0);

      // Wrap-around through port b
      for (int i = 1; i <= 7; i++) begin
         send(16'(i), 1'b1);
         check("wrap_b_level", {30'h0, b_level}, 1);
      end
      idle(3);
      check("wrap_b_empty", {30'h0, b_level}, 0);
      check("wrap_q_empty", exp_b.size(), 0);

      // Reset mid-operation
      a_ready = 1'b0; b_ready = 1'b0;
      send(16'h1234, 1'b0);
      send(16'h5678, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_a_valid",  {31'h0, a_valid}, 0);
      check("mrst_b_valid",  {31'h0, b_valid}, 0);
      check("mrst_a_level",  {30'h0, a_level}, 0);
      check("mrst_b_level",  {30'h0, b_level}, 0);
      check("mrst_in_ready", {31'h0, in_ready}, 1);
      check("mrst_a_data",   {16'h0, a_data}, 0);
      exp_a.delete();
      exp_b.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(16'h5A5A, 1'b0);
      check("post_a_valid", {31'h0, a_valid}, 1);
      check("post_a_data",  {16'h0, a_data}, 32'h5A5A);
      check("post_b_valid", {31'h0, b_valid}, 0);
      a_ready = 1'b1;
      idle(3);

      check("end_qa_empty", exp_a.size(), 0);
      check("end_qb_empty", exp_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
